// File: rtl/fg_pkg.sv
// Shared types and helpers for the function generator output path.
// Holds the amplitude ramp state enum and the sample shift helper.
package fg_pkg;

  typedef enum logic [1:0] {
    AMP_IDLE,
    AMP_ATTACK,
    AMP_DECAY
  } amp_state_t;

  // data arrives pre-extended to 32 bits (sign- or zero-), so the
  // low bits of the result are the correctly filled narrow sample
  function automatic logic [31:0] amp_shift(
    input logic [31:0] data,
    input logic [4:0]  sh,
    input logic        signed_mode
  );
    if (signed_mode)
      return 32'($signed(data) >>> sh);
    return data >> sh;
  endfunction

endpackage

// File: rtl/amp_ramp_ctrl.sv
// Attenuation ramp controller: target, applied shift, step counter.
// Ports: clk, rst_n, in_valid, sel_load, sel -> cur_shift, busy.
module amp_ramp_ctrl
  import fg_pkg::*;
#(
  parameter int SHIFT_W  = 3,
  parameter int RAMP_DIV = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               sel_load,
  input  logic [SHIFT_W-1:0] sel,
  output logic [SHIFT_W-1:0] cur_shift,
  output logic               busy
);

  localparam int CW = $clog2(RAMP_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = '1;

  amp_state_t         state, state_nxt;
  logic [SHIFT_W-1:0] tgt, tgt_nxt, cur_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= AMP_IDLE;
      tgt       <= SHIFT_MAX;
      cur_shift <= SHIFT_MAX;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      cur_shift <= cur_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    cur_nxt   = cur_shift;
    cnt_nxt   = cnt;

    // step heads for the old target even if a load lands now
    if (state != AMP_IDLE && in_valid) begin
      if (cnt == LAST) begin
        cnt_nxt = '0;
        if (state == AMP_ATTACK)
          cur_nxt = cur_shift - SHIFT_W'(1);
        else
          cur_nxt = cur_shift + SHIFT_W'(1);
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

    if (sel_load)
      tgt_nxt = sel;

    unique case (1'b1)
      (cur_nxt > tgt_nxt): state_nxt = AMP_ATTACK;
      (cur_nxt < tgt_nxt): state_nxt = AMP_DECAY;
      default:             state_nxt = AMP_IDLE;
    endcase

    // cadence survives a retarget, but not settling
    if (state_nxt == AMP_IDLE)
      cnt_nxt = '0;
  end

  assign busy = (state != AMP_IDLE);

endmodule

// File: rtl/amplitude_scaler.sv
// Click-free power-of-two amplitude stage, one-cycle latency.
// Ports: in_valid/in_data, sel_load/sel -> out_valid/out_data, cur_shift, busy.
module amplitude_scaler
  import fg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SHIFT_W  = 3,
  parameter int RAMP_DIV = 16,
  parameter bit SIGNED   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               sel_load,
  input  logic [SHIFT_W-1:0] sel,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SHIFT_W-1:0] cur_shift,
  output logic               busy
);

  logic [31:0] ext;

  assign ext = SIGNED ? 32'($signed(in_data)) : 32'(in_data);

  amp_ramp_ctrl #(
    .SHIFT_W  (SHIFT_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sel_load  (sel_load),
    .sel       (sel),
    .cur_shift (cur_shift),
    .busy      (busy)
  );

  // samples use the pre-step shift of this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        out_data <= DATA_W'(amp_shift(ext, 5'(cur_shift), SIGNED));
    end
  end

endmodule

// File: tb/tb_amplitude_scaler.sv
// Directed bench for amplitude_scaler.
// Default instance plus a signed, RAMP_DIV=1 instance.
module tb_amplitude_scaler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v0 = 0, l0 = 0;
  logic [7:0] d0 = 0;
  logic [2:0] s0 = 0;
  logic       ov0, bz0;
  logic [7:0] od0;
  logic [2:0] cs0;

  logic       v1 = 0, l1 = 0;
  logic [7:0] d1 = 0;
  logic [2:0] s1 = 0;
  logic       ov1, bz1;
  logic [7:0] od1;
  logic [2:0] cs1;

  int checks = 0;
  int failures = 0;

  logic [7:0] sexp [0:4];

  always #5 clk = ~clk;

  amplitude_scaler u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v0),
    .in_data   (d0),
    .sel_load  (l0),
    .sel       (s0),
    .out_valid (ov0),
    .out_data  (od0),
    .cur_shift (cs0),
    .busy      (bz0)
  );

  amplitude_scaler #(
    .SIGNED   (1'b1),
    .RAMP_DIV (1)
  ) u_sgn (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_data   (d1),
    .sel_load  (l1),
    .sel       (s1),
    .out_valid (ov1),
    .out_data  (od1),
    .cur_shift (cs1),
    .busy      (bz1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic feed0(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) begin
      v0 = 1'b1;
      d0 = d;
      cyc();
    end
    v0 = 1'b0;
  endtask

  initial begin
    sexp[0] = 8'hFF;
    sexp[1] = 8'hFE;
    sexp[2] = 8'hFC;
    sexp[3] = 8'hF9;
    sexp[4] = 8'hF2;

    cyc();
    cyc();
    chk("rst_ov", ov0, 0);
    chk("rst_od", od0, 0);
    chk("rst_cs", cs0, 7);
    chk("rst_bz", bz0, 0);
    rst_n = 1'b1;

    v0 = 1; d0 = 8'hFF;
    cyc();
    chk("ff_ov", ov0, 1);
    chk("ff_od", od0, 8'h01);
    chk("ff_bz", bz0, 0);
    v0 = 0;
    cyc();
    chk("idle_ov", ov0, 0);
    chk("idle_hold", od0, 8'h01);

    l0 = 1; s0 = 0;
    cyc();
    l0 = 0;
    chk("atk_bz", bz0, 1);
    chk("atk_cs", cs0, 7);
    for (int i = 0; i < 112; i++) begin
      logic [7:0] e;
      e = 8'h80 >> (7 - i / 16);
      v0 = 1; d0 = 8'h80;
      cyc();
      chk("sweep_od", od0, e);
      chk("sweep_cs", cs0, 7 - (i + 1) / 16);
    end
    v0 = 0;
    chk("sweep_bz", bz0, 0);
    feed0(1, 8'h80);
    chk("full_od", od0, 8'h80);

    l0 = 1; s0 = 7;
    cyc();
    l0 = 0;
    chk("dec_bz", bz0, 1);
    feed0(20, 8'h80);
    chk("dec_cs", cs0, 1);
    chk("dec_od", od0, 8'h40);
    chk("dec_ov", ov0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", ov0, 0);
    chk("arst_od", od0, 0);
    chk("arst_cs", cs0, 7);
    chk("arst_bz", bz0, 0);
    cyc();
    rst_n = 1'b1;

    l0 = 1; s0 = 0;
    cyc();
    l0 = 0;
    chk("re_bz", bz0, 1);
    feed0(64, 8'h80);
    chk("re_cs3", cs0, 3);
    feed0(5, 8'h80);
    v0 = 1; d0 = 8'h80; l0 = 1; s0 = 5;
    cyc();
    v0 = 0; l0 = 0;
    chk("rt_cs", cs0, 3);
    chk("rt_bz", bz0, 1);
    feed0(9, 8'h80);
    chk("rt_hold", cs0, 3);
    feed0(1, 8'h80);
    chk("rt_step4", cs0, 4);
    feed0(16, 8'h80);
    chk("rt_cs5", cs0, 5);
    chk("rt_bz0", bz0, 0);
    chk("rt_od", od0, 8'h08);

    l1 = 1; s1 = 2;
    cyc();
    l1 = 0;
    chk("s_bz", bz1, 1);
    for (int k = 0; k < 5; k++) begin
      v1 = 1; d1 = 8'h90;
      cyc();
      v1 = 0;
      chk("s_ov", ov1, 1);
      chk("s_od", od1, sexp[k]);
      chk("s_cs", cs1, 6 - k);
      cyc();
      chk("s_gap_ov", ov1, 0);
      chk("s_gap_cs", cs1, 6 - k);
      cyc();
      cyc();
    end
    chk("s_bz0", bz1, 0);
    v1 = 1; d1 = 8'h90;
    cyc();
    chk("s_m112", od1, 8'hE4);
    d1 = 8'hFF;
    cyc();
    v1 = 0;
    chk("s_m1", od1, 8'hFF);
    chk("s_cs2", cs1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amplitude_scaler.md
# amplitude_scaler

Parametrised, click-free amplitude stage for the function generator output path. It scales each waveform sample by a power-of-two attenuation (right shift by 0..2^SHIFT_W-1). Requested attenuation changes are applied gradually, one shift step per RAMP_DIV accepted samples, rather than instantly. It sits between the waveform generator and the DAC driver. It supersedes the fixed 8-bit, 4-level selector.

## Interface
- DATA_W, 8, sample width; legal range 4..32
- SHIFT_W, 3, attenuation code width; constraint 2**SHIFT_W <= DATA_W
- RAMP_DIV, 16, accepted samples per attenuation step; legal range >= 1
- SIGNED, 0, 1 = two's-complement samples with arithmetic shift; 0 = unsigned samples with logical shift
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  DATA_W  input sample
- sel_load  in  1  latch sel as the new target attenuation
- sel  in  SHIFT_W  target shift amount; 0 = full scale
- out_valid  out  1  out_data carries a scaled sample
- out_data  out  DATA_W  scaled sample
- cur_shift  out  SHIFT_W  attenuation currently applied
- busy  out  1  high while cur_shift != target

## Operation
- Registers: target (tgt), cur_shift, step counter cnt (width clog2(RAMP_DIV)+1), state.
- Reset values:
  - tgt = cur_shift = SHIFT_MAX (2**SHIFT_W-1)
  - cnt = 0, state = IDLE
  - out_valid = 0, out_data = 0, busy = 0
- States:
  - IDLE: cur_shift == tgt
  - ATTACK: cur_shift > tgt; shift decrements, amplitude rises
  - DECAY: cur_shift < tgt; shift increments
- Transitions are evaluated each cycle from the next-cycle values of tgt and cur_shift. In IDLE, cnt is held at 0.
- Ramp step: in ATTACK or DECAY, each cycle with in_valid=1 increments cnt.
  - When cnt == RAMP_DIV-1 and in_valid=1, cur_shift moves one step toward tgt and cnt clears.
  - RAMP_DIV=1 therefore steps on every accepted sample.
- sel_load=1 sets tgt <= sel on any cycle, including mid-ramp.
  - Direction is recomputed against the current cur_shift.
  - cnt is not cleared, so the step cadence is preserved.
  - If sel equals cur_shift, the block goes to IDLE and cnt clears.
- Simultaneous sel_load and ramp step: the step moves cur_shift toward the old tgt. The new tgt takes effect from the next cycle.
- Arithmetic:
  - SIGNED=1: out_data = $signed(in_data) >>> cur_shift. Sign is preserved; -1 stays -1 at any shift.
  - SIGNED=0: out_data = in_data >> cur_shift, with zero fill.
  - There is no rounding. Output width equals input width.
- The shift applied to a sample is the cur_shift value before any step taken in the same cycle.
- When in_valid=0, out_data holds its last value.
- The block has no back-pressure. Every valid input produces exactly one valid output.

## Timing
- Latency is 1 cycle: in_valid at edge N gives out_valid and out_data at edge N+1. Full throughput: 1 sample/cycle.
- busy and cur_shift are registered and reflect state after the edge. busy rises the cycle after a sel_load that differs from cur_shift.
- A full sweep of D steps takes D*RAMP_DIV accepted samples, independent of how many idle cycles fall between them.
- Reset asserted mid-ramp returns all registers to their reset values immediately, with no wait for the clock. out_valid drops at once.
- Reset deassertion must be synchronised externally to clk.

## Structure
- The shared package fg_pkg holds:
  - the state enum amp_state_t {AMP_IDLE, AMP_ATTACK, AMP_DECAY}
  - the helper function amp_shift(data, sh, signed_mode)
- Sub-module amp_ramp_ctrl contains the FSM, cnt, tgt and cur_shift.
  - Inputs: in_valid, sel_load, sel.
  - Outputs: cur_shift, busy.
- The top level holds the datapath register and the out_valid flop.

## Test plan
- Reset then in_valid=1, in_data=0xFF, default parameters → out_data=0x01 (shift 7) one cycle later; busy=0.
- sel_load with sel=0 from reset, continuous samples of 0x80 → cur_shift steps 7→6…→0 every 16 samples; out_data 0x01, 0x02 … 0x80; busy falls after sample 112.
- SIGNED=1, cur_shift=2, in_data=0x90 (-112) → out_data=0xE4 (-28); in_data=0xFF → 0xFF.
- Mid-ramp retarget: ramping 7→0, sel_load sel=5 when cur_shift=3 → state switches to DECAY; cur_shift reaches 5 after 2 more steps with no lost cadence.
- Gapped input (in_valid 1-in-4 cycles), RAMP_DIV=1 → exactly one step per valid sample; out_valid pattern mirrors in_valid delayed by 1.
- rst_n pulsed low mid-ramp → outputs zero and cur_shift=7 within the same cycle, without waiting for a clock edge; the next sel_load restarts the ramp cleanly.
